// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
//
// Divides a WIDTH-bit dividend by a WIDTH-bit divisor, as signed two's
// complement (sgn=1) or unsigned (sgn=0), giving a quotient that truncates
// toward zero and a remainder that carries the dividend's sign.
//
// Handshake: a request is accepted on any rising edge where start=1 and
// the FSM is IDLE (busy=0). Operands and sgn are captured on that edge and
// later changes are ignored. done is a one-cycle pulse. quotient, remainder,
// dbz and ovf are valid in the done cycle and hold until the next done or
// reset. A new start may be presented in the done cycle itself.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   start      division request, sampled only while idle
//   sgn        1 = signed operands, 0 = unsigned
//   dividend   numerator
//   divisor    denominator
//   quotient   registered quotient
//   remainder  registered remainder
//   busy       high while an accepted division is iterating or fixing up
//   done       one-cycle result-valid pulse
//   dbz        divide-by-zero flag (quotient all ones, remainder = raw dividend)
//   ovf        signed overflow flag (MIN / -1)
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH:0]   p_reg;     // partial remainder; MSB is the subtraction borrow
    logic [WIDTH-1:0] q_reg;     // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_reg;   // divisor magnitude
    logic [WIDTH-1:0] raw_dvd;   // unmodified dividend, returned as remainder on divide-by-zero
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             ovf_pend;
    logic             dbz_pend;  // zero divisor accepted last edge; report on this edge

    logic             accept;
    logic             div_zero;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand conditioning. The magnitude of MIN wraps to the same bit
    // pattern, which reads correctly as an unsigned WIDTH-bit value.
    always_comb begin
        accept   = (state == IDLE) && start;
        div_zero = (divisor == '0);
        dvd_neg  = sgn && dividend[WIDTH-1];
        dvs_neg  = sgn && divisor[WIDTH-1];
        dvd_mag  = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_mag  = dvs_neg ? (~divisor + 1'b1) : divisor;
    end

    // One restoring step and the sign fix-up.
    always_comb begin
        shifted = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_reg};
        q_fix   = neg_q ? (~q_reg + 1'b1) : q_reg;
        r_fix   = neg_r ? (~p_reg[WIDTH-1:0] + 1'b1) : p_reg[WIDTH-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_next;
    end

    // FSM next state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && !div_zero) state_next = ITER;
            ITER: if (cnt == CW'(1))       state_next = FIX;
            FIX:                           state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Datapath registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            p_reg    <= '0;
            q_reg    <= '0;
            dvs_reg  <= '0;
            raw_dvd  <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ovf_pend <= 1'b0;
            dbz_pend <= 1'b0;
        end else begin
            dbz_pend <= accept && div_zero;
            if (accept) begin
                p_reg    <= '0;
                q_reg    <= dvd_mag;
                dvs_reg  <= dvs_mag;
                raw_dvd  <= dividend;
                cnt      <= CW'(WIDTH);
                neg_q    <= dvd_neg ^ dvs_neg;
                neg_r    <= dvd_neg;
                ovf_pend <= sgn && (dividend == MIN_VAL) && (divisor == '1);
            end else if (state == ITER) begin
                if (!trial[WIDTH]) begin
                    p_reg <= trial;
                    q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                end else begin
                    p_reg <= shifted;
                    q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                end
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Result registers: change only on a done edge or on reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FIX) begin
                done <= 1'b1;
                dbz  <= 1'b0;
                ovf  <= ovf_pend;
                if (ovf_pend) begin
                    quotient  <= MIN_VAL;
                    remainder <= '0;
                end else begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                end
            end else if (dbz_pend) begin
                done      <= 1'b1;
                dbz       <= 1'b1;
                ovf       <= 1'b0;
                quotient  <= '1;
                remainder <= raw_dvd;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider at WIDTH=8. Expected values are
// hand-computed constants; every check is an immediate assertion.
module tb_seq_divider;

    logic       clk;
    logic       clr;
    logic       start;
    logic       sgn;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;
    logic       ovf;

    int errors = 0;
    int checks = 0;
    int lat;

    seq_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .sgn       (sgn),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until done is seen high, bounded.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 40);
    endtask

    // Present a request, let it be accepted, scramble operands, wait for done
    // and check results. Returns positioned in the done cycle.
    task automatic run_div(input logic s, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic ed, input logic eo, input int elat,
                           input string tag);
        int n;
        sgn      = s;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        sgn      = ~s;
        dividend = 8'(($urandom_range(1, 255)));
        divisor  = 8'(($urandom_range(1, 255)));
        chk({tag, ".busy_after_accept"}, busy, !ed);
        chk({tag, ".no_early_done"}, done, 1'b0);
        wait_done(n);
        chk({tag, ".latency"}, n, elat);
        chk({tag, ".quotient"}, quotient, eq);
        chk({tag, ".remainder"}, remainder, er);
        chk({tag, ".dbz"}, dbz, ed);
        chk({tag, ".ovf"}, ovf, eo);
        chk({tag, ".busy_at_done"}, busy, 1'b0);
    endtask

    // Step past the done cycle and confirm the pulse drops while results hold.
    task automatic after_done(input logic [7:0] eq, input logic [7:0] er, input string tag);
        tick();
        chk({tag, ".done_pulse_ends"}, done, 1'b0);
        chk({tag, ".quotient_held"}, quotient, eq);
        chk({tag, ".remainder_held"}, remainder, er);
    endtask

    initial begin
        clr      = 1'b0;
        start    = 1'b0;
        sgn      = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        #12;
        chk("reset.quotient", quotient, 8'h00);
        chk("reset.remainder", remainder, 8'h00);
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        chk("reset.dbz", dbz, 1'b0);
        chk("reset.ovf", ovf, 1'b0);
        tick();
        clr = 1'b1;
        tick();

        // Unsigned basic.
        run_div(1'b0, 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 1'b0, 9, "u200_7");
        after_done(8'h1C, 8'h04, "u200_7");

        // Signed: truncation toward zero, remainder follows dividend sign.
        run_div(1'b1, 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0, 9, "s-100_7");
        after_done(8'hF2, 8'hFE, "s-100_7");
        run_div(1'b1, 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 9, "s100_-7");
        after_done(8'hF2, 8'h02, "s100_-7");
        run_div(1'b1, 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 9, "s-100_-7");
        after_done(8'h0E, 8'hFE, "s-100_-7");

        // Divide by zero, both signedness modes, raw dividend returned.
        run_div(1'b0, 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 1'b0, 1, "dbz_u55");
        after_done(8'hFF, 8'd55, "dbz_u55");
        run_div(1'b1, 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 1'b0, 1, "dbz_s55");
        after_done(8'hFF, 8'd55, "dbz_s55");
        run_div(1'b1, 8'hFB, 8'd0, 8'hFF, 8'hFB, 1'b1, 1'b0, 1, "dbz_s-5");
        after_done(8'hFF, 8'hFB, "dbz_s-5");

        // Overflow and the MIN magnitude as unsigned.
        run_div(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 9, "ovf_min_-1");
        after_done(8'h80, 8'h00, "ovf_min_-1");
        run_div(1'b0, 8'd128, 8'd255, 8'h00, 8'd128, 1'b0, 1'b0, 9, "u128_255");
        after_done(8'h00, 8'd128, "u128_255");
        run_div(1'b1, 8'h80, 8'd2, 8'hC0, 8'h00, 1'b0, 1'b0, 9, "s-128_2");
        after_done(8'hC0, 8'h00, "s-128_2");
        run_div(1'b0, 8'd5, 8'd9, 8'h00, 8'd5, 1'b0, 1'b0, 9, "u5_9");
        after_done(8'h00, 8'd5, "u5_9");

        // Back-to-back: start held high in the done cycle.
        run_div(1'b0, 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b0, 9, "b2b_first");
        sgn      = 1'b0;
        dividend = 8'd9;
        divisor  = 8'd2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("b2b.busy_after_accept", busy, 1'b1);
        chk("b2b.first_held", quotient, 8'd10);
        wait_done(lat);
        chk("b2b.latency", lat, 9);
        chk("b2b.quotient", quotient, 8'd4);
        chk("b2b.remainder", remainder, 8'd1);
        after_done(8'd4, 8'd1, "b2b_second");

        // start pulsed mid-iteration is ignored.
        sgn      = 1'b0;
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        tick();
        dividend = 8'd1;
        divisor  = 8'd1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("ignored.busy", busy, 1'b1);
        wait_done(lat);
        chk("ignored.latency", lat, 5);
        chk("ignored.quotient", quotient, 8'h1C);
        chk("ignored.remainder", remainder, 8'h04);
        tick();
        tick();
        chk("ignored.no_second_done", done, 1'b0);
        chk("ignored.idle", busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) chk("ignored.spurious_done", done, 1'b0);
        end

        // Reset four cycles into ITER.
        sgn      = 1'b0;
        dividend = 8'd100;
        divisor  = 8'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("rst_mid.busy_before", busy, 1'b1);
        clr = 1'b0;
        #1;
        chk("rst_mid.quotient", quotient, 8'h00);
        chk("rst_mid.remainder", remainder, 8'h00);
        chk("rst_mid.busy", busy, 1'b0);
        chk("rst_mid.done", done, 1'b0);
        chk("rst_mid.dbz", dbz, 1'b0);
        chk("rst_mid.ovf", ovf, 1'b0);
        tick();
        tick();
        clr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) chk("rst_mid.quiet_after_release", {done, busy}, 2'b00);
        end
        chk("rst_mid.quotient_still_zero", quotient, 8'h00);
        run_div(1'b0, 8'd77, 8'd3, 8'd25, 8'd2, 1'b0, 1'b0, 9, "after_rst_77_3");
        after_done(8'd25, 8'd2, "after_rst_77_3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
